// File: rtl/hms_display_if.sv
// Bundle for the hms_display data path: time sample and strobe in,
// multiplexed seven-segment drive and conversion status out.
interface hms_display_if;
  logic [18:0] HMS_time;
  logic        half_sec_pulse;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        busy;

  modport master (output HMS_time, half_sec_pulse, input seg, dp, an, busy);
  modport slave  (input HMS_time, half_sec_pulse, output seg, dp, an, busy);
endinterface

// File: rtl/hms_display.sv
// HH MM SS display back-end: per-field subtract-by-ten BCD conversion and a
// 6-digit active-low multiplexed seven-segment scanner with blinking colons.

module hms_bcd_lane (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] load_val,
  output logic       done,
  output logic       ovf,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [6:0] val_q, val_d;
  logic [3:0] tens_q, tens_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    val_d  = val_q;
    tens_d = tens_q;
    ovf_d  = ovf_q;
    if (load) begin
      val_d  = load_val;
      tens_d = '0;
      ovf_d  = (load_val > 7'd99);
    end else if (step && !ovf_q && (val_q >= 7'd10)) begin
      val_d  = val_q - 7'd10;
      tens_d = tens_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      val_q  <= '0;
      tens_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      val_q  <= val_d;
      tens_q <= tens_d;
      ovf_q  <= ovf_d;
    end
  end

  // An overflowed field never subtracts, so it counts as finished at once.
  assign done = ovf_q || (val_q < 7'd10);
  assign ovf  = ovf_q;
  assign tens = tens_q;
  assign ones = val_q[3:0];
endmodule

module hms_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic          clock,
  input  logic          reset,
  hms_display_if.slave  bus
);
  localparam int NUM_FIELDS = 3;
  localparam int NUM_DIGITS = 6;
  localparam int DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic {IDLE, CONV} state_t;

  state_t state_q, state_d;

  logic [NUM_FIELDS-1:0][6:0] field_in;
  logic [NUM_FIELDS-1:0]      lane_done, lane_ovf;
  logic [NUM_FIELDS-1:0][3:0] lane_tens, lane_ones;
  logic                       load, step, all_done;

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic                       busy_q, busy_d;
  logic                       colon_q, colon_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [2:0]                 idx_q, idx_d;
  logic [5:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [3:0]                 cur_dig;
  logic                       tc;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      DASH:    seg_decode = 7'b0111111;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Lane 0 = seconds, 1 = minutes, 2 = hours.
  assign field_in[0] = {1'b0, bus.HMS_time[5:0]};
  assign field_in[1] = {1'b0, bus.HMS_time[11:6]};
  assign field_in[2] = bus.HMS_time[18:12];

  assign load     = (state_q == IDLE) && bus.half_sec_pulse;
  assign step     = (state_q == CONV);
  assign all_done = &lane_done;

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_lane
    hms_bcd_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .load_val (field_in[i]),
      .done     (lane_done[i]),
      .ovf      (lane_ovf[i]),
      .tens     (lane_tens[i]),
      .ones     (lane_ones[i])
    );
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.half_sec_pulse) state_d = CONV;
      CONV: begin
        busy_d = !all_done;
        if (all_done) begin
          state_d = IDLE;
          for (int i = 0; i < NUM_FIELDS; i++) begin
            dig_d[2*i]   = lane_ovf[i] ? DASH : lane_ones[i];
            dig_d[2*i+1] = lane_ovf[i] ? DASH : lane_tens[i];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign colon_d = colon_q ^ bus.half_sec_pulse;

  // Scanner: an/seg only move on the index change, dp follows colon every cycle.
  always_comb begin
    tc    = (div_q == DIV_LAST);
    div_d = tc ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    case (idx_d)
      3'd0:    cur_dig = dig_q[0];
      3'd1:    cur_dig = dig_q[1];
      3'd2:    cur_dig = dig_q[2];
      3'd3:    cur_dig = dig_q[3];
      3'd4:    cur_dig = dig_q[4];
      3'd5:    cur_dig = dig_q[5];
      default: cur_dig = dig_q[0];
    endcase

    an_d  = an_q;
    seg_d = seg_q;
    if (tc) begin
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (idx_d != 3'(i));
      seg_d = seg_decode(cur_dig);
    end
    dp_d = !(colon_q && ((idx_d == 3'd2) || (idx_d == 3'd4)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      colon_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= 6'b111110;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      colon_q <= colon_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
endmodule

// File: doc/hms_display.md
# hms_display

Display back-end for the `timing` block. Samples `HMS_time` on each `half_sec_pulse` and converts hours, minutes and seconds to BCD with a sequential subtract-by-ten engine. Drives a 6-digit, common-anode, time-multiplexed seven-segment display as HH MM SS. The decimal-point colons blink at the half-second rate.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit stays enabled (legal values ≥2).
- `clock`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `HMS_time`  in  19: [18:12] hours, [11:6] minutes, [5:0] seconds; all fields unsigned binary.
- `half_sec_pulse`  in  1: one-cycle strobe from `timing`.
- `seg`  out  7: {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.
- `an`  out  6: digit enables, active-low; bit 0 is seconds-ones, bit 5 is hours-tens.
- `busy`  out  1: high while a conversion is in progress.

## Operation
- FSM states: IDLE and CONV. Reset enters IDLE.
- **IDLE.**
  - When `half_sec_pulse`=1, load the three fields into working registers.
  - Clear the three tens counters.
  - Set a per-field overflow flag if the field value is >99.
  - Go to CONV.
- **CONV.** On each clock edge, for each field ≥10: subtract 10 and increment that field's tens counter. Fields that are already <10 hold.
- **CONV exit.** On the first edge where all three fields are <10:
  - Copy tens and ones into the six display digit registers.
  - Go to IDLE.
  - An overflowed field instead loads the DASH code into both of its digits, with no subtraction performed for it.
- **Pulse during CONV:** ignored; the captured value still completes.
- **Colon.**
  - `colon_on` toggles on every `half_sec_pulse`, in either state.
  - When `colon_on`=1, `dp`=0 while digit 2 or digit 4 is enabled; otherwise `dp`=1.
- **Scan.**
  - Divider counts 0..SCAN_DIV-1.
  - On the terminal count it wraps to 0 and the digit index advances 0→1→…→5→0.
- **Segment decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - DASH=0111111
- Minutes and seconds values 60–63 are not errors; they display as decimal (e.g. 63 → "63").

## Timing
- **Reset values:**
  - Outputs: `an`=111110, `seg`=1000000, `dp`=1, `busy`=0.
  - Internal: all digit registers 0, `colon_on`=0, divider 0, index 0.
- **Conversion latency.** Let k = max tens digit over the non-overflowed fields.
  - The digit registers update on edge k+1 after the edge that sampled the pulse.
  - k=0 gives 1 edge; 99 gives 10 edges, which is the maximum.
- **`busy`:** 1 from the edge after capture through the edge that updates the digit registers, where it falls.
- **Output registering:** `an`, `seg` and `dp` are registered and change on the same edge as the index.
  - New digit values appear on the display on the next index change or later, never mid-digit.
- **Colon timing:** the `colon_on` toggle is visible on `dp` the edge after the pulse, if digit 2 or 4 is enabled.
- **Reset mid-conversion:** aborts immediately; all state returns to reset values on that edge.
- **Pulse and reset together:** reset wins.

## Test plan
- **Reset:** assert `reset` for 5 cycles with `SCAN_DIV`=4 -> `an`=111110, `seg`=1000000, `dp`=1, `busy`=0. After release, `an` steps 111101, 111011, … every 4 cycles and wraps to 111110 after 24 cycles.
- **Basic conversion:** `HMS_time`={7'd12,6'd34,6'd56}, pulse once -> `busy` high for exactly 5 edges (k=5). Digits 5..0 then read 1,2,3,4,5,6; digit 0 shows `seg`=0000010.
- **Maximum latency and overflow:**
  - Hours=99, minutes=59, seconds=0 -> update after 10 edges; digits read 9,9,5,9,0,0.
  - Hours=100 -> digits 5 and 4 show 0111111.
- **Colon blink:** apply 3 pulses -> `colon_on` sequence 1,0,1. `dp`=0 only while `an`=111011 or 101111 with `colon_on`=1.
- **Pulse during CONV:** second pulse 2 cycles after the first with a different `HMS_time` -> first value is displayed; the conversion is not restarted.
- **Reset mid-conversion:** `reset` asserted 3 cycles into CONV -> next cycle `busy`=0, all digits 0, `an`=111110.
